// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the sprite motion block: FSM state encoding,
// default screen bounds, datapath widths and a saturating counter helper.
// ---------------------------------------------------------------------------
package game_pkg;

  localparam int POS_W = 10;  // screen coordinate width
  localparam int VEL_W = 6;   // signed per-tick step width
  localparam int SUM_W = 12;  // signed width of pos + vel, wide enough to never wrap
  localparam int CNT_W = 10;  // cooldown counter width (COOLDOWN up to 1023)
  localparam int DTH_W = 8;   // death counter width

  // Default legal screen area for the sprite's top-left corner.
  localparam int DEF_X_MIN = 3;
  localparam int DEF_X_MAX = 639;
  localparam int DEF_Y_MIN = 3;
  localparam int DEF_Y_MAX = 479;

  typedef enum logic {
    ST_ALIVE = 1'b0,
    ST_DEAD  = 1'b1
  } sprite_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DTH_W-1:0] sat_inc(input logic [DTH_W-1:0] v);
    return (v == {DTH_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sprite_edge_chk.sv
// ---------------------------------------------------------------------------
// sprite_edge_chk
// One axis of the sprite's motion: forms the candidate next position and
// flags when it would leave the legal [min, max] range.
//
// Ports
//   pos_i  [POS_W-1:0]        current coordinate (unsigned)
//   vel_i  [VEL_W-1:0] signed per-tick step
//   min_i  [POS_W-1:0]        lowest legal coordinate
//   max_i  [POS_W-1:0]        highest legal coordinate
//   next_o [POS_W-1:0]        candidate coordinate (meaningful when hit_o = 0)
//   hit_o                     candidate is outside [min_i, max_i]
// ---------------------------------------------------------------------------
module sprite_edge_chk
  import game_pkg::*;
(
  input  logic        [POS_W-1:0] pos_i,
  input  logic signed [VEL_W-1:0] vel_i,
  input  logic        [POS_W-1:0] min_i,
  input  logic        [POS_W-1:0] max_i,
  output logic        [POS_W-1:0] next_o,
  output logic                    hit_o
);

  logic signed [SUM_W-1:0] sum_s;
  logic signed [SUM_W-1:0] min_s;
  logic signed [SUM_W-1:0] max_s;

  // Widen everything to a common signed width so a step past zero reads as
  // negative rather than wrapping to a large unsigned coordinate.
  assign sum_s = $signed({{(SUM_W-POS_W){1'b0}}, pos_i})
               + $signed({{(SUM_W-VEL_W){vel_i[VEL_W-1]}}, vel_i});
  assign min_s = $signed({{(SUM_W-POS_W){1'b0}}, min_i});
  assign max_s = $signed({{(SUM_W-POS_W){1'b0}}, max_i});

  assign hit_o  = (sum_s < min_s) || (sum_s > max_s);
  assign next_o = sum_s[POS_W-1:0];

endmodule

// File: rtl/sprite_move.sv
// ---------------------------------------------------------------------------
// sprite_move
// Moves a sprite by a signed velocity on every enabled tick. Leaving the
// screen either kills it (MODE 0) or reflects the offending axis (MODE 1).
// A kill input also kills it. A dead sprite waits COOLDOWN ticks at the
// spawn point, then comes back with the initial velocity and a one-cycle
// respawn pulse.
//
// Ports
//   clk_22      clock
//   rst         synchronous active-high reset
//   tick        one-cycle step enable for motion and cooldown
//   pause       level; freezes motion and cooldown
//   kill        level; hit event, ignored while dead
//   pos_x [9:0] current x (top-left)
//   pos_y [9:0] current y (top-left)
//   show_valid  high while alive
//   respawn     one-cycle pulse on the first cycle after coming back alive
//   deaths [7:0] number of deaths, saturating at 255
// ---------------------------------------------------------------------------
module sprite_move
  import game_pkg::*;
#(
  parameter int                       SCR_X_MIN = DEF_X_MIN,
  parameter int                       SCR_X_MAX = DEF_X_MAX,
  parameter int                       SCR_Y_MIN = DEF_Y_MIN,
  parameter int                       SCR_Y_MAX = DEF_Y_MAX,
  parameter int                       START_X   = 560,
  parameter int                       START_Y   = 60,
  parameter logic signed [VEL_W-1:0]  VEL_X     = -6'sd2,
  parameter logic signed [VEL_W-1:0]  VEL_Y     = 6'sd2,
  parameter int                       COOLDOWN  = 100,
  parameter int                       MODE      = 0
) (
  input  logic             clk_22,
  input  logic             rst,
  input  logic             tick,
  input  logic             pause,
  input  logic             kill,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             show_valid,
  output logic             respawn,
  output logic [DTH_W-1:0] deaths
);

  localparam logic [POS_W-1:0] START_X_C = POS_W'(START_X);
  localparam logic [POS_W-1:0] START_Y_C = POS_W'(START_Y);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(COOLDOWN - 1);

  sprite_state_e           state_q, state_d;
  logic        [POS_W-1:0] pos_x_q, pos_x_d;
  logic        [POS_W-1:0] pos_y_q, pos_y_d;
  logic signed [VEL_W-1:0] vel_x_q, vel_x_d;
  logic signed [VEL_W-1:0] vel_y_q, vel_y_d;
  logic        [CNT_W-1:0] cnt_q,   cnt_d;
  logic        [DTH_W-1:0] deaths_q, deaths_d;
  logic                    respawn_q, respawn_d;

  logic             step;
  logic             die;
  logic [POS_W-1:0] next_x, next_y;
  logic             hit_x, hit_y;

  assign step = tick & ~pause;

  sprite_edge_chk u_chk_x (
    .pos_i  (pos_x_q),
    .vel_i  (vel_x_q),
    .min_i  (POS_W'(SCR_X_MIN)),
    .max_i  (POS_W'(SCR_X_MAX)),
    .next_o (next_x),
    .hit_o  (hit_x)
  );

  sprite_edge_chk u_chk_y (
    .pos_i  (pos_y_q),
    .vel_i  (vel_y_q),
    .min_i  (POS_W'(SCR_Y_MIN)),
    .max_i  (POS_W'(SCR_Y_MAX)),
    .next_o (next_y),
    .hit_o  (hit_y)
  );

  // NOTE: every variable driven here gets a default first, so no path through
  // the case/if tree leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    vel_x_d   = vel_x_q;
    vel_y_d   = vel_y_q;
    cnt_d     = cnt_q;
    deaths_d  = deaths_q;
    respawn_d = 1'b0;
    die       = 1'b0;

    unique case (state_q)
      ST_ALIVE: begin
        // kill wins over any edge handling on the same cycle and is honoured
        // even when the sprite is not stepping.
        if (kill) begin
          die = 1'b1;
        end else if (step) begin
          if (MODE == 0) begin
            if (hit_x || hit_y) begin
              die = 1'b1;
            end else begin
              pos_x_d = next_x;
              pos_y_d = next_y;
            end
          end else begin
            // Reflect each offending axis independently; the other keeps moving.
            if (hit_x) vel_x_d = -vel_x_q;
            else       pos_x_d = next_x;
            if (hit_y) vel_y_d = -vel_y_q;
            else       pos_y_d = next_y;
          end
        end
      end

      ST_DEAD: begin
        if (step) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = ST_ALIVE;
            vel_x_d   = VEL_X;
            vel_y_d   = VEL_Y;
            cnt_d     = '0;
            respawn_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: ;
    endcase

    // Dying parks the sprite at the spawn point for the whole cooldown.
    if (die) begin
      state_d  = ST_DEAD;
      pos_x_d  = START_X_C;
      pos_y_d  = START_Y_C;
      cnt_d    = '0;
      deaths_d = sat_inc(deaths_q);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_22) begin
    if (rst) begin
      state_q   <= ST_ALIVE;
      pos_x_q   <= START_X_C;
      pos_y_q   <= START_Y_C;
      vel_x_q   <= VEL_X;
      vel_y_q   <= VEL_Y;
      cnt_q     <= '0;
      deaths_q  <= '0;
      respawn_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      vel_x_q   <= vel_x_d;
      vel_y_q   <= vel_y_d;
      cnt_q     <= cnt_d;
      deaths_q  <= deaths_d;
      respawn_q <= respawn_d;
    end
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign show_valid = (state_q == ST_ALIVE);
  assign respawn    = respawn_q;
  assign deaths     = deaths_q;

endmodule
